note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Song-playback front end for the square-wave tone generator. Steps a registered
//  note ROM one address per beat, latches each note code, and drives fullnote plus
//  an articulation gate into the tone generator. Adds start/pause/stop control,
//  end-of-song detection (note code 0) and optional looping for the game FSM.
// PARAMETERS
//  BEAT_DIV    4194304  clocks per step (2^22); must be > GAP_CYCLES
//  GAP_CYCLES  262144   silent clocks at the start of each step (2^18); must be >= 2
//  ADDR_W      8        ROM address width
//  LOOP        0        1 = restart at address 0 after end of song
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       async reset, active low
//  start        in   1       level; sampled each clk; begins playback from address 0
//  pause        in   1       level; freezes playback while high
//  stop         in   1       level; aborts playback; highest priority
//  rom_addr     out  ADDR_W  address to note ROM (registered)
//  rom_note     in   8       ROM data; ROM registers it, valid 1 clk after rom_addr
//  fullnote     out  8       latched note code to tone generator (0 = silent)
//  note_gate    out  1       1 = tone generator may toggle speaker
//  busy         out  1       1 in FETCH or PLAY
//  song_done    out  1       1-clk pulse at end of song
// BEHAVIOUR
//  Reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All
//   outputs are 0, state = IDLE, and the step counter cnt = 0.
//  States: IDLE, FETCH, PLAY, DONE. cnt is $clog2(BEAT_DIV) bits wide and counts
//   0..BEAT_DIV-1 across each step, including the FETCH cycles.
//  IDLE/DONE: start=1 && stop=0 -> rom_addr<=0, cnt<=0, state FETCH.
//  FETCH is 2 clocks (cnt=0,1). The ROM sees the address during cnt=0, and rom_note
//   is valid during cnt=1. At the edge leaving cnt=1, rom_note is sampled:
//   - rom_note!=0 -> fullnote<=rom_note, state PLAY.
//   - rom_note==0 -> end of song: fullnote<=0, song_done=1 for 1 clk.
//     LOOP=0: state DONE. LOOP=1: rom_addr<=0, cnt<=0, state FETCH.
//  PLAY: cnt increments each clk. At cnt==BEAT_DIV-1: cnt<=0, state FETCH, and
//   rom_addr<=rom_addr+1. If rom_addr is at its maximum, this is end of song
//   (same handling as rom_note==0; no wrap to 0 unless LOOP=1).
//  fullnote holds its previous value during FETCH (the gate is low there).
//  note_gate = (state==PLAY) && !pause && cnt>=GAP_CYCLES && fullnote!=0.
//   It is combinational from registers, with no extra latency.
//  busy = state is FETCH or PLAY.
//  pause (FETCH/PLAY only): cnt, rom_addr and state freeze, and note_gate=0.
//   The step resumes where it stopped. pause in IDLE/DONE is ignored.
//  stop: in any state, the next clk gives state IDLE, rom_addr=0, fullnote=0,
//   cnt=0, song_done=0. stop overrides start and pause in the same cycle.
//  start while busy is ignored; a restart requires stop or DONE.
//  Async reset mid-playback: immediate return to reset values, no song_done pulse.
// TESTING (BEAT_DIV=16, GAP_CYCLES=4, ROM model: 1-clk registered, {25,27,0,...})
//  1 rst_n=0 then 1, no start -> all outputs 0 for 50 clks; pause/stop toggles
//    have no effect.
//  2 start for 1 clk (edge P0) -> rom_addr=0; fullnote=25 from P0+2;
//    note_gate high P0+4..P0+15; rom_addr=1 at P0+16; fullnote=27 from P0+18;
//    song_done pulse at P0+34; busy low from P0+34; fullnote=0.
//  3 pause high 10 clks at cnt=8 of step 0 -> note_gate low during the pause;
//    cnt held at 8; rom_addr advances at P0+26 instead of P0+16.
//  4 stop at cnt=6 of step 1 -> next clk: IDLE, all outputs 0.
//    start+stop in the same clk from IDLE -> stays IDLE.
//  5 LOOP=1 -> song_done pulse at P0+34; rom_addr=0 same edge;
//    fullnote=25 again at P0+36; busy stays 1.
//  6 rst_n low asynchronously mid-PLAY (between edges) -> outputs 0 immediately;
//    no song_done pulse; start after release plays from address 0.

Source files
------------

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps a registered note ROM one address per beat and drives fullnote plus an articulation gate
// Start/pause/stop playback control, end-of-song on note code 0 or last address, optional looping.
module note_sequencer #(
  parameter int unsigned BEAT_DIV   = 4194304,
  parameter int unsigned GAP_CYCLES = 262144,
  parameter int unsigned ADDR_W     = 8,
  parameter bit          LOOP       = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_note,
  output logic [7:0]        fullnote,
  output logic              note_gate,
  output logic              busy,
  output logic              song_done
);

  localparam int unsigned      CNT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        note_q, note_d;
  logic              done_q, done_d;
  logic              end_song;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      note_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    note_d   = note_q;
    done_d   = 1'b0;
    end_song = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      addr_d  = '0;
      note_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_FETCH;
            cnt_d   = '0;
            addr_d  = '0;
          end
        end
        S_FETCH: begin
          if (!pause) begin
            cnt_d = cnt_q + CNT_ONE;
            // rom_note is valid on the second fetch cycle only
            if (cnt_q == CNT_ONE) begin
              if (rom_note == 8'd0) begin
                end_song = 1'b1;
              end else begin
                note_d  = rom_note;
                state_d = S_PLAY;
              end
            end
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              if (addr_q == ADDR_MAX) begin
                end_song = 1'b1;
              end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (end_song) begin
        note_d = '0;
        done_d = 1'b1;
        cnt_d  = '0;
        if (LOOP) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end else begin
          state_d = S_DONE;
        end
      end
    end
  end

  assign rom_addr  = addr_q;
  assign fullnote  = note_q;
  assign song_done = done_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_PLAY);
  // The leading gap of each step articulates repeated notes
  assign note_gate = (state_q == S_PLAY) && !pause && (cnt_q >= CNT_GAP) && (note_q != 8'd0);

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - bench for note_sequencer, one non-looping and one looping instance
// Step/tick song model plus literal timeline checks, then randomized control and ROM contents.
module tb_note_sequencer;
  localparam int BEAT = 16;
  localparam int GAP  = 4;
  localparam int AW   = 3;
  localparam int NA   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic stop = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rom [NA];
  logic [AW-1:0] a0, a1;
  logic [7:0]    rq0, rq1, fn0, fn1;
  logic          g0, g1, b0, b1, sd0, sd1;

  note_sequencer #(.BEAT_DIV(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW), .LOOP(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
    .rom_addr(a0), .rom_note(rq0), .fullnote(fn0), .note_gate(g0),
    .busy(b0), .song_done(sd0));

  note_sequencer #(.BEAT_DIV(BEAT), .GAP_CYCLES(GAP), .ADDR_W(AW), .LOOP(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
    .rom_addr(a1), .rom_note(rq1), .fullnote(fn1), .note_gate(g1),
    .busy(b1), .song_done(sd1));

  always @(posedge clk) begin
    rq0 <= rom[a0];
    rq1 <= rom[a1];
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: playing flag, song position (step), tick within the step, held note.
  int m_act [2];
  int m_step [2];
  int m_tick [2];
  int m_note [2];
  int m_done [2];

  task automatic model_end(input int d);
    m_note[d] = 0;
    m_done[d] = 1;
    m_tick[d] = 0;
    if (d == 1) m_step[d] = 0;
    else m_act[d] = 0;
  endtask

  task automatic model_step(input int d);
    m_done[d] = 0;
    if (stop) begin
      m_act[d] = 0; m_step[d] = 0; m_tick[d] = 0; m_note[d] = 0;
    end else if (m_act[d] == 0) begin
      if (start) begin
        m_act[d] = 1; m_step[d] = 0; m_tick[d] = 0;
      end
    end else if (!pause) begin
      if (m_tick[d] == 1 && rom[m_step[d]] == 8'd0) model_end(d);
      else if (m_tick[d] == 1) begin
        m_note[d] = rom[m_step[d]];
        m_tick[d] = 2;
      end else if (m_tick[d] == BEAT - 1 && m_step[d] == NA - 1) model_end(d);
      else if (m_tick[d] == BEAT - 1) begin
        m_step[d] = m_step[d] + 1;
        m_tick[d] = 0;
      end else m_tick[d] = m_tick[d] + 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_act[d] = 0; m_step[d] = 0; m_tick[d] = 0; m_note[d] = 0; m_done[d] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check_dut(input int d, input int ad, input int fn, input int g, input int b, input int sd);
    int eg;
    eg = (m_act[d] != 0 && m_tick[d] >= GAP && !pause && m_note[d] != 0) ? 1 : 0;
    cmp($sformatf("u%0d.rom_addr", d), ad, m_step[d]);
    cmp($sformatf("u%0d.fullnote", d), fn, m_note[d]);
    cmp($sformatf("u%0d.note_gate", d), g, eg);
    cmp($sformatf("u%0d.busy", d), b, m_act[d]);
    cmp($sformatf("u%0d.song_done", d), sd, m_done[d]);
  endtask

  always @(negedge clk) begin
    check_dut(0, a0, fn0, g0, b0, sd0);
    check_dut(1, a1, fn1, g1, b1, sd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NA; i++) rom[i] = 8'd0;
    rom[0] = 8'd25;
    rom[1] = 8'd27;
    repeat (3) tick();
    rst_n = 1'b1;

    // idle: pause/stop toggles do nothing
    for (int i = 0; i < 50; i++) begin
      pause = 1'($urandom_range(0, 1));
      stop  = 1'($urandom_range(0, 1));
      tick();
      cmp("idle.busy", b0, 0);
      cmp("idle.fullnote", fn0, 0);
      cmp("idle.gate", g0, 0);
      cmp("idle.done", sd0, 0);
    end
    pause = 1'b0;
    stop  = 1'b0;
    tick();

    // plain playback timeline from start edge P0
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp("p.addr0", a0, 0);
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 2)  cmp("p.fn25", fn0, 25);
      if (k == 3)  cmp("p.gate_gap", g0, 0);
      if (k == 4)  cmp("p.gate_on", g0, 1);
      if (k == 15) cmp("p.gate_last", g0, 1);
      if (k == 16) begin cmp("p.addr1", a0, 1); cmp("p.gate_fetch", g0, 0); end
      if (k == 17) cmp("p.fn_hold", fn0, 25);
      if (k == 18) cmp("p.fn27", fn0, 27);
      if (k == 34) begin
        cmp("p.done", sd0, 1); cmp("p.busy_low", b0, 0); cmp("p.fn0", fn0, 0);
        cmp("loop.done", sd1, 1); cmp("loop.addr0", a1, 0); cmp("loop.busy", b1, 1);
      end
      if (k == 35) cmp("p.done_pulse", sd0, 0);
      if (k == 36) cmp("loop.fn25", fn1, 25);
    end
    do_stop();

    // pause 10 clocks at cnt=8 of step 0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 12) cmp("pz.gate_low", g0, 0);
      if (k == 20) cmp("pz.gate_resume", g0, 1);
      if (k == 25) cmp("pz.addr_held", a0, 0);
      if (k == 26) cmp("pz.addr_adv", a0, 1);
      if (k == 8)  pause = 1'b1;
      if (k == 18) pause = 1'b0;
    end
    do_stop();

    // stop at cnt=6 of step 1
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 22) stop = 1'b1;
    end
    stop = 1'b0;
    cmp("st.busy", b0, 0);
    cmp("st.fn", fn0, 0);
    cmp("st.addr", a0, 0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    cmp("ss.busy0", b0, 0);
    cmp("ss.busy1", b1, 0);

    // asynchronous reset mid-play
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    cmp("ar.busy", b0, 0);
    cmp("ar.fn", fn0, 0);
    cmp("ar.gate", g0, 0);
    cmp("ar.done", sd0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    cmp("ar.fn25", fn0, 25);
    cmp("ar.addr0", a0, 0);
    do_stop();

    // randomized songs and control
    for (int t = 0; t < 40; t++) begin
      do_stop();
      for (int i = 0; i < NA; i++) begin
        if (t % 4 != 0 && $urandom_range(0, 4) == 0) rom[i] = 8'd0;
        else rom[i] = 8'($urandom_range(1, 255));
      end
      for (int c = 0; c < 200; c++) begin
        start = ($urandom_range(0, 9) == 0);
        pause = ($urandom_range(0, 7) == 0);
        stop  = ($urandom_range(0, 59) == 0);
        tick();
      end
      start = 1'b0;
      pause = 1'b0;
    end

    do_stop();
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
